// File: rtl/contrast_sweep_ctrl_pkg.sv
// Shared types and helpers for the contrast-box blocks (sweep sequencer,
// PWM generator, button front-end).
package contrast_box_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_ACK,
    ST_STEP,
    ST_DONE
  } sweep_state_t;

  // Millisecond interval to clock cycles, evaluated at elaboration time.
  function automatic logic [63:0] ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (64'(freq) * 64'(ms)) / 64'd1000;
  endfunction

endpackage

// File: rtl/contrast_sweep_ctrl_if.sv
// Command/handshake bundle between the sweep sequencer and its surroundings.
// master = environment (buttons, host, sample consumer); slave = sequencer.
interface contrast_sweep_ctrl_if #(
  parameter int unsigned PWM_REG_WIDTH = 10
);
  logic                     start;
  logic                     abort;
  logic [PWM_REG_WIDTH-1:0] manual_value;
  logic                     manual_changed;
  logic                     sample_ack;
  logic                     sample_req;
  logic [PWM_REG_WIDTH-1:0] pwm_on_time;
  logic                     pwm_on_value_changed;
  logic                     busy;
  logic                     done;
  logic                     manual_blocked;
  logic                     timeout_err;

  modport master (
    output start, abort, manual_value, manual_changed, sample_ack,
    input  sample_req, pwm_on_time, pwm_on_value_changed, busy, done,
           manual_blocked, timeout_err
  );

  modport slave (
    input  start, abort, manual_value, manual_changed, sample_ack,
    output sample_req, pwm_on_time, pwm_on_value_changed, busy, done,
           manual_blocked, timeout_err
  );
endinterface

// File: rtl/contrast_sweep_ctrl_timer.sv
// Interval counter shared by the settle and ack-timeout phases.
// tc is high during the last cycle of a limit-cycle interval (immediately when limit is 0).
module cb_interval_timer #(
  parameter int unsigned TIMER_BIT = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMER_BIT-1:0] limit,
  output logic                 tc
);
  logic [TIMER_BIT-1:0] count;
  logic [TIMER_BIT:0]   count_inc;

  assign count_inc = {1'b0, count} + {{TIMER_BIT{1'b0}}, 1'b1};
  assign tc        = count_inc >= {1'b0, limit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc[TIMER_BIT-1:0];
    end
  end
endmodule

// File: rtl/contrast_sweep_ctrl.sv
// Contrast sweep sequencer: ramps the PWM setpoint START..END, settles,
// handshakes a sample per step; forwards manual setpoints when idle.
module contrast_sweep_ctrl
  import contrast_box_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 16000000,
  parameter int unsigned PWM_REG_WIDTH   = 10,
  parameter int unsigned PWM_CYCLE       = 1023,
  parameter int unsigned START_VALUE     = 0,
  parameter int unsigned STEP_VALUE      = 11,
  parameter int unsigned END_VALUE       = 1023,
  parameter int unsigned SETTLE_TIME_MS  = 50,
  parameter int unsigned ACK_TIMEOUT_MS  = 100,
  parameter int unsigned TIMER_BIT       = 27
) (
  input logic                 clk,
  input logic                 reset,
  contrast_sweep_ctrl_if.slave bus
);
  localparam int unsigned WX = PWM_REG_WIDTH + 1;
  localparam logic [TIMER_BIT-1:0] SETTLE_CYC =
    TIMER_BIT'(ms_to_cycles(CLOCK_FREQUENCY, SETTLE_TIME_MS));
  localparam logic [TIMER_BIT-1:0] ACK_CYC =
    TIMER_BIT'(ms_to_cycles(CLOCK_FREQUENCY, ACK_TIMEOUT_MS));
  localparam logic [PWM_REG_WIDTH-1:0] START_V = PWM_REG_WIDTH'(START_VALUE);
  // An END beyond the PWM period could never be reached safely; cap it there.
  localparam logic [PWM_REG_WIDTH-1:0] END_V = (END_VALUE > PWM_CYCLE) ?
    PWM_REG_WIDTH'(PWM_CYCLE) : PWM_REG_WIDTH'(END_VALUE);
  localparam logic [WX-1:0] STEP_X = WX'(STEP_VALUE);

  sweep_state_t             state_q, state_d;
  logic [PWM_REG_WIDTH-1:0] pwm_q, pwm_d, saved_q, saved_d, next_val;
  logic [WX-1:0]            sum;
  logic req_q, req_d, chg_q, chg_d, busy_q, busy_d;
  logic done_q, done_d, blocked_q, blocked_d, terr_q, terr_d;
  logic tmr_clear, tmr_en, tmr_tc;
  logic [TIMER_BIT-1:0] tmr_limit;

  assign sum      = {1'b0, pwm_q} + STEP_X;
  assign next_val = (sum > {1'b0, END_V}) ? END_V : sum[PWM_REG_WIDTH-1:0];

  // Timer restarts on every state change, so one counter serves both phases.
  assign tmr_clear = (state_d != state_q);
  assign tmr_en    = (state_q == ST_SETTLE) || (state_q == ST_WAIT_ACK);
  assign tmr_limit = (state_q == ST_WAIT_ACK) ? ACK_CYC : SETTLE_CYC;

  cb_interval_timer #(.TIMER_BIT(TIMER_BIT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .limit  (tmr_limit),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    pwm_d     = pwm_q;
    saved_d   = saved_q;
    req_d     = req_q;
    busy_d    = busy_q;
    terr_d    = terr_q;
    chg_d     = 1'b0;
    done_d    = 1'b0;
    blocked_d = busy_q && bus.manual_changed;
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      pwm_d   = saved_q;
      chg_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            saved_d = pwm_q;
            terr_d  = 1'b0;
            pwm_d   = START_V;
            chg_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SETTLE;
          end else if (bus.manual_changed && !bus.start) begin
            pwm_d = bus.manual_value;
            chg_d = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_tc) begin
            req_d   = 1'b1;
            state_d = ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (bus.sample_ack) begin
            req_d   = 1'b0;
            state_d = ST_STEP;
          end else if (tmr_tc) begin
            req_d   = 1'b0;
            terr_d  = 1'b1;
            state_d = ST_STEP;
          end
        end
        ST_STEP: begin
          if (pwm_q == END_V) begin
            state_d = ST_DONE;
          end else begin
            pwm_d   = next_val;
            chg_d   = 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pwm_q     <= '0;
      saved_q   <= '0;
      req_q     <= 1'b0;
      chg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= pwm_d;
      saved_q   <= saved_d;
      req_q     <= req_d;
      chg_q     <= chg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      blocked_q <= blocked_d;
      terr_q    <= terr_d;
    end
  end

  assign bus.sample_req           = req_q;
  assign bus.pwm_on_time          = pwm_q;
  assign bus.pwm_on_value_changed = chg_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.manual_blocked       = blocked_q;
  assign bus.timeout_err          = terr_q;
endmodule

// File: tb/tb_contrast_sweep_ctrl.sv
// Randomized self-checking bench for contrast_sweep_ctrl: a ramp DUT (0/11/30)
// and a single-point DUT (5/5/5), checked against a setpoint-list model.
module tb_contrast_sweep_ctrl;
  localparam int FREQ    = 16000;
  localparam int SET_CYC = FREQ * 2 / 1000;
  localparam int ACK_CYC = FREQ * 4 / 1000;
  localparam int M_START = 0;
  localparam int M_STEP  = 11;
  localparam int M_END   = 30;
  localparam int O_VAL   = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_pts[$];

  contrast_sweep_ctrl_if #(.PWM_REG_WIDTH(10)) bm ();
  contrast_sweep_ctrl_if #(.PWM_REG_WIDTH(10)) bo ();

  contrast_sweep_ctrl #(
    .CLOCK_FREQUENCY(FREQ), .PWM_REG_WIDTH(10), .PWM_CYCLE(1023),
    .START_VALUE(M_START), .STEP_VALUE(M_STEP), .END_VALUE(M_END),
    .SETTLE_TIME_MS(2), .ACK_TIMEOUT_MS(4), .TIMER_BIT(27)
  ) dut_m (.clk(clk), .reset(rst), .bus(bm));

  contrast_sweep_ctrl #(
    .CLOCK_FREQUENCY(FREQ), .PWM_REG_WIDTH(10), .PWM_CYCLE(1023),
    .START_VALUE(O_VAL), .STEP_VALUE(5), .END_VALUE(O_VAL),
    .SETTLE_TIME_MS(2), .ACK_TIMEOUT_MS(4), .TIMER_BIT(27)
  ) dut_o (.clk(clk), .reset(rst), .bus(bo));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Ramp model: every setpoint the sweep must sample, END included exactly once.
  function automatic void build_points();
    int v;
    exp_pts.delete();
    v = M_START;
    exp_pts.push_back(v);
    while (v < M_END) begin
      v = (v + M_STEP > M_END) ? M_END : v + M_STEP;
      exp_pts.push_back(v);
    end
  endfunction

  // Counts cycles until sample_req is seen; stray acks are thrown in meanwhile.
  task automatic wait_req(input int budget, output int cyc);
    cyc = 0;
    while (bm.sample_req !== 1'b1 && cyc < budget) begin
      bm.sample_ack = ($urandom_range(0, 3) == 0);
      tick();
      cyc++;
    end
    bm.sample_ack = 1'b0;
  endtask

  task automatic ack_after(input int d);
    repeat (d) tick();
    check_eq("req_held", bm.sample_req, 1);
    bm.sample_ack = 1'b1;
    tick();
    bm.sample_ack = 1'b0;
    check_eq("req_drop_after_ack", bm.sample_req, 0);
  endtask

  task automatic pulse_start();
    bm.start = 1'b1;
    tick();
    bm.start = 1'b0;
  endtask

  task automatic run_sweep(input bit allow_to);
    int c, h;
    bit to_seen;
    to_seen = 1'b0;
    build_points();
    pulse_start();
    check_eq("start_busy", bm.busy, 1);
    check_eq("start_pulse", bm.pwm_on_value_changed, 1);
    check_eq("start_value", bm.pwm_on_time, exp_pts[0]);
    check_eq("start_clears_terr", bm.timeout_err, 0);
    for (int i = 0; i < exp_pts.size(); i++) begin
      wait_req(SET_CYC + 20, c);
      check_eq("settle_cycles", c, SET_CYC);
      if (bm.sample_req !== 1'b1) return;
      check_eq("sample_point", bm.pwm_on_time, exp_pts[i]);
      if (allow_to && $urandom_range(0, 2) == 0) begin
        h = 0;
        while (bm.sample_req === 1'b1 && h < ACK_CYC + 20) begin
          tick();
          h++;
        end
        check_eq("ack_timeout_len", h, ACK_CYC);
        check_eq("timeout_err_set", bm.timeout_err, 1);
        to_seen = 1'b1;
      end else begin
        ack_after($urandom_range(0, 5));
      end
      tick();
      if (i < exp_pts.size() - 1) begin
        check_eq("step_pulse", bm.pwm_on_value_changed, 1);
        check_eq("step_value", bm.pwm_on_time, exp_pts[i + 1]);
      end else begin
        check_eq("no_load_at_end", bm.pwm_on_value_changed, 0);
        tick();
        check_eq("done", bm.done, 1);
        check_eq("busy_end", bm.busy, 0);
        check_eq("end_value", bm.pwm_on_time, M_END);
        check_eq("terr_sticky", bm.timeout_err, int'(to_seen));
        tick();
        check_eq("done_one_cycle", bm.done, 0);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c, h, mv, k, p0;
    bit seen;
    rst = 1'b1;
    bm.start = 0; bm.abort = 0; bm.manual_value = '0; bm.manual_changed = 0; bm.sample_ack = 0;
    bo.start = 0; bo.abort = 0; bo.manual_value = '0; bo.manual_changed = 0; bo.sample_ack = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_pwm", bm.pwm_on_time, 0);
    check_eq("rst_req", bm.sample_req, 0);
    check_eq("rst_busy", bm.busy, 0);
    check_eq("rst_done", bm.done, 0);
    check_eq("rst_terr", bm.timeout_err, 0);
    check_eq("rst_chg", bm.pwm_on_value_changed, 0);

    // Manual update while idle
    mv = $urandom_range(100, 900);
    bm.manual_value = 10'(mv); bm.manual_changed = 1'b1;
    tick();
    bm.manual_changed = 1'b0;
    check_eq("manual_value", bm.pwm_on_time, mv);
    check_eq("manual_pulse", bm.pwm_on_value_changed, 1);
    tick();
    check_eq("manual_pulse_len", bm.pwm_on_value_changed, 0);

    run_sweep(1'b0);
    repeat (3) run_sweep(1'b1);

    // start + abort together in idle: nothing happens
    p0 = bm.pwm_on_time;
    bm.start = 1'b1; bm.abort = 1'b1;
    tick();
    bm.start = 1'b0; bm.abort = 1'b0;
    check_eq("sa_busy", bm.busy, 0);
    check_eq("sa_chg", bm.pwm_on_value_changed, 0);
    check_eq("sa_pwm", bm.pwm_on_time, p0);
    repeat (SET_CYC + 3) tick();
    check_eq("sa_no_req", bm.sample_req, 0);

    // Abort during the second settle returns to the manual setpoint
    mv = $urandom_range(150, 250);
    bm.manual_value = 10'(mv); bm.manual_changed = 1'b1;
    tick();
    bm.manual_changed = 1'b0;
    pulse_start();
    wait_req(SET_CYC + 20, c);
    ack_after($urandom_range(0, 4));
    tick();
    check_eq("abort_step_value", bm.pwm_on_time, M_START + M_STEP);
    k = $urandom_range(1, SET_CYC - 2);
    repeat (k) tick();
    bm.abort = 1'b1;
    tick();
    bm.abort = 1'b0;
    check_eq("abort_req", bm.sample_req, 0);
    check_eq("abort_busy", bm.busy, 0);
    check_eq("abort_restore", bm.pwm_on_time, mv);
    check_eq("abort_pulse", bm.pwm_on_value_changed, 1);
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (bm.done === 1'b1 || bm.sample_req === 1'b1) seen = 1'b1;
    end
    check_eq("abort_quiet", int'(seen), 0);

    // Abort wins over a same-cycle ack while the request is up
    pulse_start();
    wait_req(SET_CYC + 20, c);
    bm.abort = 1'b1; bm.sample_ack = 1'b1;
    tick();
    bm.abort = 1'b0; bm.sample_ack = 1'b0;
    check_eq("abort_wait_req", bm.sample_req, 0);
    check_eq("abort_wait_restore", bm.pwm_on_time, mv);
    repeat (3) tick();
    check_eq("abort_wait_no_done", bm.done, 0);

    // manual_changed and start while busy
    p0 = bm.pwm_on_time;
    pulse_start();
    tick();
    bm.manual_value = 10'd77; bm.manual_changed = 1'b1; bm.start = 1'b1;
    tick();
    bm.manual_changed = 1'b0; bm.start = 1'b0;
    check_eq("blocked_pulse", bm.manual_blocked, 1);
    check_eq("blocked_pwm", bm.pwm_on_time, M_START);
    check_eq("blocked_no_chg", bm.pwm_on_value_changed, 0);
    tick();
    check_eq("blocked_len", bm.manual_blocked, 0);
    wait_req(SET_CYC + 20, c);
    check_eq("start_busy_ignored", c, SET_CYC - 3);
    bm.abort = 1'b1;
    tick();
    bm.abort = 1'b0;
    check_eq("abort_saved", bm.pwm_on_time, p0);

    // Asynchronous reset while the request is high
    pulse_start();
    wait_req(SET_CYC + 20, c);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_req", bm.sample_req, 0);
    check_eq("async_pwm", bm.pwm_on_time, 0);
    check_eq("async_busy", bm.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst_busy", bm.busy, 0);
    bm.manual_value = 10'd321; bm.manual_changed = 1'b1;
    tick();
    bm.manual_changed = 1'b0;
    check_eq("post_rst_idle_manual", bm.pwm_on_time, 321);

    // Single-point sweep with no consumer: timeout path
    bo.start = 1'b1;
    tick();
    bo.start = 1'b0;
    check_eq("o_start_value", bo.pwm_on_time, O_VAL);
    c = 0;
    while (bo.sample_req !== 1'b1 && c < SET_CYC + 20) begin
      tick();
      c++;
    end
    check_eq("o_settle", c, SET_CYC);
    h = 0;
    while (bo.sample_req === 1'b1 && h < ACK_CYC + 20) begin
      tick();
      h++;
    end
    check_eq("o_timeout_len", h, ACK_CYC);
    check_eq("o_terr", bo.timeout_err, 1);
    repeat (2) tick();
    check_eq("o_done", bo.done, 1);
    check_eq("o_end", bo.pwm_on_time, O_VAL);
    tick();
    check_eq("o_terr_kept", bo.timeout_err, 1);
    bo.start = 1'b1;
    tick();
    bo.start = 1'b0;
    check_eq("o_terr_cleared", bo.timeout_err, 0);
    check_eq("o_busy_again", bo.busy, 1);
    bo.abort = 1'b1;
    tick();
    bo.abort = 1'b0;
    check_eq("o_abort_busy", bo.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/contrast_sweep_ctrl.md
Name: contrast_sweep_ctrl

Overview:
Sequencer for the contrast-box PWM datapath. It steps the PWM on-time setpoint through a programmed ramp (START to END in STEP increments). After each step it waits a settle time, then performs a req/ack handshake with a sample consumer (ADC/logger) before advancing. Outside a sweep it forwards manual setpoint updates from the button front-end to the PWM generator.

Parameters:
CLOCK_FREQUENCY, 16000000, clk frequency in Hz
PWM_REG_WIDTH, 10, width of PWM on-time setpoint
PWM_CYCLE, 1023, max legal on-time; must be < 2^PWM_REG_WIDTH
START_VALUE, 0, first setpoint of sweep
STEP_VALUE, 11, increment per step; must be ≥1
END_VALUE, 1023, last setpoint; START_VALUE ≤ END_VALUE ≤ PWM_CYCLE
SETTLE_TIME_MS, 50, wait after each setpoint change before sampling
ACK_TIMEOUT_MS, 100, max wait for sample_ack
TIMER_BIT, 27, width of the settle/timeout counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  one-cycle pulse; cancels a running sweep
manual_value  in  PWM_REG_WIDTH  setpoint from button front-end
manual_changed  in  1  pulse; manual_value is new
sample_ack  in  1  consumer has taken the sample
sample_req  out  1  level request to sample at the current setpoint
pwm_on_time  out  PWM_REG_WIDTH  setpoint to the PWM generator
pwm_on_value_changed  out  1  one-cycle pulse when pwm_on_time changes
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal sweep completion
manual_blocked  out  1  pulse; a manual_changed arrived while busy
timeout_err  out  1  sticky; set on an ack timeout, cleared by the next accepted start or by reset

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high.
- Reset values: all outputs 0, pwm_on_time=0, state IDLE, counters 0.
- Derived constants: SETTLE_CYC = CLOCK_FREQUENCY*SETTLE_TIME_MS/1000 and ACK_CYC = CLOCK_FREQUENCY*ACK_TIMEOUT_MS/1000, both evaluated at elaboration.
- State IDLE:
  - manual_changed → pwm_on_time ← manual_value, with pwm_on_value_changed the next cycle.
  - start (and no abort) → save the current pwm_on_time to saved_val, clear timeout_err, set pwm_on_time ← START_VALUE, pulse pwm_on_value_changed, busy=1, go to SETTLE.
  - If start and manual_changed coincide, start wins and the manual value is discarded.
- State SETTLE: the timer counts 0..SETTLE_CYC-1. On terminal count, sample_req←1 and go to WAIT_ACK. Consequently sample_req rises SETTLE_CYC+1 cycles after the start pulse. SETTLE_CYC=0 means sample_req rises 1 cycle after entry.
- State WAIT_ACK:
  - sample_req is held high until sample_ack is sampled high; it drops on the following edge.
  - If the ack is not seen within ACK_CYC cycles, sample_req drops, timeout_err←1, and the sweep proceeds to STEP anyway.
  - sample_ack outside WAIT_ACK is ignored.
- State STEP:
  - If pwm_on_time == END_VALUE → go to DONE.
  - Otherwise compute next = pwm_on_time + STEP_VALUE in PWM_REG_WIDTH+1 bits. If next > END_VALUE, clamp to END_VALUE.
  - Load next, pulse pwm_on_value_changed, go to SETTLE.
  - The END value is therefore always sampled exactly once.
- State DONE: done pulse for one cycle, busy←0, go to IDLE. pwm_on_time keeps END_VALUE.
- abort (any non-IDLE state):
  - sample_req←0 immediately on the next edge and busy←0.
  - pwm_on_time ← saved_val with a pwm_on_value_changed pulse; no done pulse.
  - Go to IDLE.
  - abort has priority over start, ack, and timer events in the same cycle.
- start while busy is ignored. manual_changed while busy is ignored and produces a manual_blocked pulse.
- pwm_on_value_changed fires only when a load occurs, even if the loaded value equals the old value.
- Number of sample handshakes per completed sweep = ceil((END_VALUE-START_VALUE)/STEP_VALUE)+1.

Decomposition:
- Package contrast_box_pkg:
  - state encoding (IDLE, SETTLE, WAIT_ACK, STEP, DONE)
  - function ms_to_cycles(freq, ms), shared with the PWM/button block
- Sub-module cb_interval_timer: TIMER_BIT-wide counter with load/clear, enable, and terminal-count compare. One instance, reused for the settle and ack-timeout phases; it is reloaded on every state entry.

Test Plan:
All scenarios use CLOCK_FREQUENCY=16000 (16 cycles/ms), SETTLE_TIME_MS=2 (32 cycles), ACK_TIMEOUT_MS=4 (64 cycles).
1. START=0, STEP=11, END=33; start, consumer acks 3 cycles after each req → 4 handshakes at setpoints 0, 11, 22, 33; first req exactly 33 cycles after start; done pulse; pwm_on_time=33.
2. START=0, STEP=11, END=30 → setpoints 0, 11, 22, 30 (clamped); 4 handshakes; done.
3. No ack ever; START=END=5 → req high 64 cycles then drops; timeout_err=1; done pulse; a new start clears timeout_err.
4. Idle with manual set to 200, then start, then abort during the second SETTLE → req stays 0; pwm_on_time returns to 200 with a change pulse; busy=0; no done.
5. Same cycle start+abort in IDLE → nothing happens. manual_changed (value 77) while busy → manual_blocked pulse, pwm_on_time unaffected.
6. Assert reset during WAIT_ACK with req high → all outputs 0 asynchronously; state IDLE after release.
